alu_system_ctrl: RTL
====================

Name: alu_system_ctrl

Overview:
- Hardwired control unit that sequences the existing ALU_System datapath (RegFile, ARF, IR, ALU, memory, MuxA/B/C).
- Fetches a 16-bit instruction as two bytes into the IR, then executes it in one cycle. Every ALU_System control input is driven from this block.
- Sits directly above ALU_System. Its outputs connect port-for-port to the ALU_System control inputs.

Parameters:
- OPC_W, 4, opcode field width, IROut[15:12].
- IMM_W, 8, immediate/address field width, IROut[7:0].

Ports:
- Clock  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-low reset.
- Run  in  1  start request; sampled only in IDLE.
- IROut  in  16  IR contents: [15:12] opcode, [11:10] Rx, [9:8] Ry, [7:0] imm.
- ALUOutFlag  in  4  latched flags {Z,C,N,O}, Z=[3].
- RF_OutASel, RF_OutBSel  out  3  RegFile read selects (000..011 = R1..R4).
- RF_FunSel  out  2  RegFile function.
- RF_RSel, RF_TSel  out  4  RegFile enables, active-high, [3]=R1..[0]=R4.
- ALU_FunSel  out  4  ALU operation.
- ARF_OutCSel, ARF_OutDSel  out  2  ARF read selects.
- ARF_FunSel  out  2  ARF function.
- ARF_RegSel  out  4  ARF enables, active-high, [3]=PC, [2]=AR, [1]=SP.
- IR_LH  out  1  0 = load low byte, 1 = load high byte.
- IR_Enable  out  1  IR load enable.
- IR_Funsel  out  2  IR function.
- Mem_WR  out  1  1 = write, 0 = read.
- Mem_CS  out  1  chip select, active-low.
- MuxASel, MuxBSel  out  2  RegFile / ARF input muxes.
- MuxCSel  out  1  ALU A-input mux.
- Halted  out  1  high in HALT.

Behaviour:
- Outputs are Moore/Mealy combinational decode of the state register plus IROut. There is no output latency beyond the state register.
- Inactive output set: all enables 0, Mem_CS=1, Mem_WR=0, all selects/FunSels 0, Halted=0.
- Reset low forces state IDLE immediately and drives the inactive set. This includes reset asserted mid-instruction; partially fetched IR bytes are abandoned.
- States and transitions:
  - IDLE: inactive set. Run=1 -> INIT; else stay.
  - INIT: ARF_RegSel=PC, ARF_FunSel=CLR. -> FETCH_L.
  - FETCH_L: ARF_OutDSel=PC, Mem_CS=0, Mem_WR=0, IR_Enable=1, IR_LH=0, IR_Funsel=LOAD; ARF_RegSel=PC, ARF_FunSel=INC. -> FETCH_H.
  - FETCH_H: same as FETCH_L with IR_LH=1. -> EXEC.
  - EXEC: decode IROut (full 16 bits valid). -> FETCH_L, except HLT -> HALT.
  - HALT: inactive set, Halted=1. Leaves only on Reset; Run is ignored.
- Instruction timing: every instruction takes exactly 3 cycles (FETCH_L, FETCH_H, EXEC). PC advances by 2 per instruction.
- EXEC decode, by opcode:
  - 0x0 LDI: MuxASel=IR, RF_FunSel=LOAD, RF_RSel=onehot(Rx).
  - 0x1 LDM: ARF_OutDSel=AR, Mem_CS=0, MuxASel=MEM, load Rx.
  - 0x2 STM: RF_OutBSel=Rx, ALU_FunSel=PASS_B, ARF_OutDSel=AR, Mem_CS=0, Mem_WR=1.
  - 0x3 ADD: RF_OutASel=Rx, RF_OutBSel=Ry, MuxCSel=RF, ALU_FunSel=ADD, MuxASel=ALU, load Rx.
  - 0x4 LDAR: MuxBSel=IR, ARF_RegSel=AR, ARF_FunSel=LOAD.
  - 0x5 BRA: MuxBSel=IR, ARF_RegSel=PC, ARF_FunSel=LOAD.
  - 0x6 BEQ: as BRA only if ALUOutFlag[3]=1; otherwise inactive set.
  - 0xF HLT: inactive set.
  - Others: NOP (inactive set), -> FETCH_L.
- Wrap-around: PC increment wraps 0xFF -> 0x00 inside the ARF; the controller takes no action.
- BEQ flag rule: BEQ samples Z as it stands at EXEC. Flags from an ADD in the immediately preceding EXEC are valid.

Decomposition:
- Package alu_system_pkg holds:
  - State enum: IDLE, INIT, FETCH_L, FETCH_H, EXEC, HALT (3-bit).
  - Opcode constants.
  - FunSel constants: DEC=00, INC=01, LOAD=10, CLR=11.
  - MuxA/MuxB codes: ALU=00, MEM=01, IR=10, ARF=11.
  - MuxC codes: ARF=0, RF=1.
  - ALU codes: PASS_A=0000, PASS_B=0001, ADD=0100.
  - ARF select codes: PC=00, AR=01, SP=11.
- One sub-module, alu_system_decode: combinational mapping of {opcode, Rx, Ry, Z} to the EXEC control word.
- The top level holds the state register and the fetch/init control words.

Test Plan:
- Reset low mid-FETCH_H -> outputs immediately inactive, Mem_CS=1, state IDLE. Release with Run=0 -> stays IDLE.
- Run=1 in IDLE -> next cycle INIT with ARF_RegSel=1000, ARF_FunSel=11. Following cycle FETCH_L with IR_LH=0, IR_Enable=1, Mem_CS=0.
- IROut=0x04AA (LDI R2,0xAA) at EXEC -> MuxASel=10, RF_FunSel=10, RF_RSel=0100. Next cycle FETCH_L.
- IROut=0x31xx (ADD R1,R1,R2) -> RF_OutASel=000, RF_OutBSel=001, ALU_FunSel=0100, MuxCSel=1, MuxASel=00, RF_RSel=1000.
- IROut=0x6040 (BEQ 0x40): Z=1 -> MuxBSel=10, ARF_RegSel=1000, ARF_FunSel=10; Z=0 -> ARF_RegSel=0000.
- IROut=0xF000 -> next state HALT, Halted=1, stays HALT for 20 cycles with Run toggling. IROut=0x7000 -> NOP, all enables 0, back to FETCH_L.

Source files
------------

// File: rtl/alu_system_pkg.sv
// Shared types and encodings for the ALU_System hardwired controller.
// The control word struct mirrors the ALU_System control inputs one field per port.
package alu_system_pkg;

   localparam int OPC_W = 4;
   localparam int IMM_W = 8;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_INIT    = 3'd1,
      S_FETCH_L = 3'd2,
      S_FETCH_H = 3'd3,
      S_EXEC    = 3'd4,
      S_HALT    = 3'd5
   } state_t;

   localparam logic [OPC_W-1:0] OP_LDI  = 4'h0;
   localparam logic [OPC_W-1:0] OP_LDM  = 4'h1;
   localparam logic [OPC_W-1:0] OP_STM  = 4'h2;
   localparam logic [OPC_W-1:0] OP_ADD  = 4'h3;
   localparam logic [OPC_W-1:0] OP_LDAR = 4'h4;
   localparam logic [OPC_W-1:0] OP_BRA  = 4'h5;
   localparam logic [OPC_W-1:0] OP_BEQ  = 4'h6;
   localparam logic [OPC_W-1:0] OP_HLT  = 4'hF;

   localparam logic [1:0] FS_DEC  = 2'b00;
   localparam logic [1:0] FS_INC  = 2'b01;
   localparam logic [1:0] FS_LOAD = 2'b10;
   localparam logic [1:0] FS_CLR  = 2'b11;

   localparam logic [1:0] MUX_ALU = 2'b00;
   localparam logic [1:0] MUX_MEM = 2'b01;
   localparam logic [1:0] MUX_IR  = 2'b10;
   localparam logic [1:0] MUX_ARF = 2'b11;

   localparam logic MUXC_ARF = 1'b0;
   localparam logic MUXC_RF  = 1'b1;

   localparam logic [3:0] ALU_PASS_A = 4'b0000;
   localparam logic [3:0] ALU_PASS_B = 4'b0001;
   localparam logic [3:0] ALU_ADD    = 4'b0100;

   localparam logic [1:0] ARF_PC = 2'b00;
   localparam logic [1:0] ARF_AR = 2'b01;
   localparam logic [1:0] ARF_SP = 2'b11;

   localparam logic [3:0] ARF_EN_PC = 4'b1000;
   localparam logic [3:0] ARF_EN_AR = 4'b0100;

   typedef struct packed {
      logic [2:0] rf_outa_sel;
      logic [2:0] rf_outb_sel;
      logic [1:0] rf_funsel;
      logic [3:0] rf_rsel;
      logic [3:0] rf_tsel;
      logic [3:0] alu_funsel;
      logic [1:0] arf_outc_sel;
      logic [1:0] arf_outd_sel;
      logic [1:0] arf_funsel;
      logic [3:0] arf_regsel;
      logic       ir_lh;
      logic       ir_enable;
      logic [1:0] ir_funsel;
      logic       mem_wr;
      logic       mem_cs;
      logic [1:0] muxa_sel;
      logic [1:0] muxb_sel;
      logic       muxc_sel;
      logic       halted;
   } ctrl_t;

   // Everything idle; memory chip select is active-low so it parks high.
   function automatic ctrl_t ctrl_inactive();
      ctrl_t c;
      c        = '0;
      c.mem_cs = 1'b1;
      return c;
   endfunction

   // Register field 00 selects R1, which sits on enable bit [3].
   function automatic logic [3:0] reg_onehot(input logic [1:0] r);
      return 4'b1000 >> r;
   endfunction

endpackage

// File: rtl/alu_system_ctrl_if.sv
// Control/status bundle between the controller (master) and the ALU_System datapath (slave).
interface alu_system_ctrl_if;
   logic        Run;
   logic [15:0] IROut;
   logic [3:0]  ALUOutFlag;
   logic [2:0]  RF_OutASel;
   logic [2:0]  RF_OutBSel;
   logic [1:0]  RF_FunSel;
   logic [3:0]  RF_RSel;
   logic [3:0]  RF_TSel;
   logic [3:0]  ALU_FunSel;
   logic [1:0]  ARF_OutCSel;
   logic [1:0]  ARF_OutDSel;
   logic [1:0]  ARF_FunSel;
   logic [3:0]  ARF_RegSel;
   logic        IR_LH;
   logic        IR_Enable;
   logic [1:0]  IR_Funsel;
   logic        Mem_WR;
   logic        Mem_CS;
   logic [1:0]  MuxASel;
   logic [1:0]  MuxBSel;
   logic        MuxCSel;
   logic        Halted;

   modport master (
      input  Run, IROut, ALUOutFlag,
      output RF_OutASel, RF_OutBSel, RF_FunSel, RF_RSel, RF_TSel, ALU_FunSel,
             ARF_OutCSel, ARF_OutDSel, ARF_FunSel, ARF_RegSel,
             IR_LH, IR_Enable, IR_Funsel, Mem_WR, Mem_CS,
             MuxASel, MuxBSel, MuxCSel, Halted
   );

   modport slave (
      output Run, IROut, ALUOutFlag,
      input  RF_OutASel, RF_OutBSel, RF_FunSel, RF_RSel, RF_TSel, ALU_FunSel,
             ARF_OutCSel, ARF_OutDSel, ARF_FunSel, ARF_RegSel,
             IR_LH, IR_Enable, IR_Funsel, Mem_WR, Mem_CS,
             MuxASel, MuxBSel, MuxCSel, Halted
   );
endinterface

// File: rtl/alu_system_decode.sv
// EXEC-cycle instruction decode: {opcode, Rx, Ry, Z} -> datapath control word.
module alu_system_decode
   import alu_system_pkg::*;
(
   input  logic [OPC_W-1:0] i_opcode,
   input  logic [1:0]       i_rx,
   input  logic [1:0]       i_ry,
   input  logic             i_z,
   output ctrl_t            o_ctrl
);

   always_comb begin
      o_ctrl = ctrl_inactive();
      case (i_opcode)
         OP_LDI: begin
            o_ctrl.muxa_sel  = MUX_IR;
            o_ctrl.rf_funsel = FS_LOAD;
            o_ctrl.rf_rsel   = reg_onehot(i_rx);
         end
         OP_LDM: begin
            o_ctrl.arf_outd_sel = ARF_AR;
            o_ctrl.mem_cs       = 1'b0;
            o_ctrl.muxa_sel     = MUX_MEM;
            o_ctrl.rf_funsel    = FS_LOAD;
            o_ctrl.rf_rsel      = reg_onehot(i_rx);
         end
         OP_STM: begin
            o_ctrl.rf_outb_sel  = {1'b0, i_rx};
            o_ctrl.alu_funsel   = ALU_PASS_B;
            o_ctrl.arf_outd_sel = ARF_AR;
            o_ctrl.mem_cs       = 1'b0;
            o_ctrl.mem_wr       = 1'b1;
         end
         OP_ADD: begin
            o_ctrl.rf_outa_sel = {1'b0, i_rx};
            o_ctrl.rf_outb_sel = {1'b0, i_ry};
            o_ctrl.muxc_sel    = MUXC_RF;
            o_ctrl.alu_funsel  = ALU_ADD;
            o_ctrl.muxa_sel    = MUX_ALU;
            o_ctrl.rf_funsel   = FS_LOAD;
            o_ctrl.rf_rsel     = reg_onehot(i_rx);
         end
         OP_LDAR: begin
            o_ctrl.muxb_sel   = MUX_IR;
            o_ctrl.arf_regsel = ARF_EN_AR;
            o_ctrl.arf_funsel = FS_LOAD;
         end
         OP_BRA: begin
            o_ctrl.muxb_sel   = MUX_IR;
            o_ctrl.arf_regsel = ARF_EN_PC;
            o_ctrl.arf_funsel = FS_LOAD;
         end
         OP_BEQ: begin
            // Z is the flag latched by the previous ALU op, including an ADD one EXEC earlier.
            if (i_z) begin
               o_ctrl.muxb_sel   = MUX_IR;
               o_ctrl.arf_regsel = ARF_EN_PC;
               o_ctrl.arf_funsel = FS_LOAD;
            end
         end
         default: o_ctrl = ctrl_inactive();
      endcase
   end

endmodule

// File: rtl/alu_system_ctrl.sv
// Hardwired sequencer for ALU_System: INIT clears PC, then a 3-cycle
// FETCH_L / FETCH_H / EXEC loop until HLT parks the block in HALT.
//
// state     | meaning
// ----------+-----------------------------------------------
// S_IDLE    | inactive outputs, waiting for Run
// S_INIT    | clear PC
// S_FETCH_L | read mem[PC] into IR low byte, PC++
// S_FETCH_H | read mem[PC] into IR high byte, PC++
// S_EXEC    | decode IROut and drive the datapath for one cycle
// S_HALT    | inactive outputs with Halted=1, exits only on reset
module alu_system_ctrl
   import alu_system_pkg::*;
(
   input  logic              i_clk,
   input  logic              i_rst_n,
   alu_system_ctrl_if.master bus
);

   state_t           r_state;
   state_t           w_state_nxt;
   ctrl_t            w_ctrl;
   ctrl_t            w_exec_ctrl;
   logic [OPC_W-1:0] w_opcode;

   assign w_opcode = bus.IROut[15:12];

   alu_system_decode u_decode (
      .i_opcode (w_opcode),
      .i_rx     (bus.IROut[11:10]),
      .i_ry     (bus.IROut[9:8]),
      .i_z      (bus.ALUOutFlag[3]),
      .o_ctrl   (w_exec_ctrl)
   );

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) r_state <= S_IDLE;
      else          r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:    if (bus.Run) w_state_nxt = S_INIT;
         S_INIT:    w_state_nxt = S_FETCH_L;
         S_FETCH_L: w_state_nxt = S_FETCH_H;
         S_FETCH_H: w_state_nxt = S_EXEC;
         S_EXEC:    w_state_nxt = (w_opcode == OP_HLT) ? S_HALT : S_FETCH_L;
         S_HALT:    w_state_nxt = S_HALT;
         default:   w_state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      w_ctrl = ctrl_inactive();
      case (r_state)
         S_INIT: begin
            w_ctrl.arf_regsel = ARF_EN_PC;
            w_ctrl.arf_funsel = FS_CLR;
         end
         S_FETCH_L, S_FETCH_H: begin
            w_ctrl.arf_outd_sel = ARF_PC;
            w_ctrl.mem_cs       = 1'b0;
            w_ctrl.mem_wr       = 1'b0;
            w_ctrl.ir_enable    = 1'b1;
            w_ctrl.ir_lh        = (r_state == S_FETCH_H);
            w_ctrl.ir_funsel    = FS_LOAD;
            w_ctrl.arf_regsel   = ARF_EN_PC;
            w_ctrl.arf_funsel   = FS_INC;
         end
         S_EXEC:  w_ctrl = w_exec_ctrl;
         S_HALT:  w_ctrl.halted = 1'b1;
         default: w_ctrl = ctrl_inactive();
      endcase
   end

   assign bus.RF_OutASel  = w_ctrl.rf_outa_sel;
   assign bus.RF_OutBSel  = w_ctrl.rf_outb_sel;
   assign bus.RF_FunSel   = w_ctrl.rf_funsel;
   assign bus.RF_RSel     = w_ctrl.rf_rsel;
   assign bus.RF_TSel     = w_ctrl.rf_tsel;
   assign bus.ALU_FunSel  = w_ctrl.alu_funsel;
   assign bus.ARF_OutCSel = w_ctrl.arf_outc_sel;
   assign bus.ARF_OutDSel = w_ctrl.arf_outd_sel;
   assign bus.ARF_FunSel  = w_ctrl.arf_funsel;
   assign bus.ARF_RegSel  = w_ctrl.arf_regsel;
   assign bus.IR_LH       = w_ctrl.ir_lh;
   assign bus.IR_Enable   = w_ctrl.ir_enable;
   assign bus.IR_Funsel   = w_ctrl.ir_funsel;
   assign bus.Mem_WR      = w_ctrl.mem_wr;
   assign bus.Mem_CS      = w_ctrl.mem_cs;
   assign bus.MuxASel     = w_ctrl.muxa_sel;
   assign bus.MuxBSel     = w_ctrl.muxb_sel;
   assign bus.MuxCSel     = w_ctrl.muxc_sel;
   assign bus.Halted      = w_ctrl.halted;

endmodule
